// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - 8-bit SPI responder, all four CPOL/CPHA modes, oversampled in the clk domain.
// Receives MSB first with a one-cycle rx_valid; fetches each transmit byte with a one-cycle tx_ack.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] txdata,
  output logic       tx_ack,
  output logic [7:0] rxdata,
  output logic       rx_valid,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       rx_valid_q, rx_valid_d;
  logic       hold_q, hold_d;
  logic       miso_q, miso_d;
  logic       tx_ack_c;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;

  always_comb begin
    sclk_sync_d    = sclk_sync_q;
    ss_sync_d      = ss_sync_q;
    mosi_sync_d    = mosi_sync_q;
    sclk_sync_d[0] = sclk;
    ss_sync_d[0]   = ss_n;
    mosi_sync_d[0] = mosi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sclk_sync_d[i] = sclk_sync_q[i-1];
      ss_sync_d[i]   = ss_sync_q[i-1];
      mosi_sync_d[i] = mosi_sync_q[i-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_prev_d = sclk_s;
  assign ss_prev_d   = ss_s;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  // Edge roles come from the mode latched at frame start, never the live input.
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rxdata_d   = rxdata_q;
    rx_valid_d = 1'b0;
    hold_d     = hold_q;
    miso_d     = miso_q;
    tx_ack_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          mode_d     = mode;
          tx_shift_d = txdata;
          tx_ack_c   = 1'b1;
          bit_cnt_d  = 3'd0;
          miso_d     = txdata[7];
          hold_d     = mode[0];
        end
      end
      ACTIVE: begin
        if (ss_s) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          bit_cnt_d = 3'd0;
          hold_d    = 1'b0;
        end else if (sample_edge) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          if (bit_cnt_q == 3'd7) begin
            rxdata_d   = {rx_shift_q[6:0], mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = 3'd0;
            tx_shift_d = txdata;
            tx_ack_c   = 1'b1;
            hold_d     = 1'b1;
            if (!mode_q[0]) begin
              miso_d = txdata[7];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (shift_edge) begin
          // hold keeps the freshly loaded MSB on miso for one extra shift edge.
          if (hold_q) begin
            miso_d = tx_shift_q[7];
            hold_d = 1'b0;
          end else begin
            miso_d     = tx_shift_q[6];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= IDLE;
      mode_q      <= 2'd0;
      bit_cnt_q   <= 3'd0;
      tx_shift_q  <= 8'd0;
      rx_shift_q  <= 8'd0;
      rxdata_q    <= 8'd0;
      rx_valid_q  <= 1'b0;
      hold_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rxdata_q    <= rxdata_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      miso_q      <= miso_d;
    end
  end

  // tx_ack is combinational so txdata is captured on the very edge that ends the ack cycle.
  assign tx_ack   = tx_ack_c & ~rst;
  assign rxdata   = rxdata_q;
  assign rx_valid = rx_valid_q;
  assign miso     = miso_q;
  assign miso_oe  = (state_q == ACTIVE);
  assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave driving a behavioural SPI master.
// Every expected byte and count below is a hand-chosen constant.
module tb_spi_slave;
  localparam int SYNC = 2;
  localparam int H    = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] txdata;
  logic       tx_ack;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       sclk;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic       busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         ack_cnt = 0;
  int         glitches = 0;
  logic [7:0] rx_log[$];

  spi_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .mode(mode), .txdata(txdata), .tx_ack(tx_ack),
    .rxdata(rxdata), .rx_valid(rx_valid), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_log.push_back(rxdata);
    if (tx_ack === 1'b1) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int idx);
    logic [7:0] v;
    v = 8'hxx;
    if (idx < rx_log.size()) v = rx_log[idx];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    repeat (H) tick();
  endtask

  task automatic frame_begin(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    half(); half();
    ss_n = 1'b0;
    half(); half();
  endtask

  task automatic frame_end();
    half();
    ss_n = 1'b1;
    repeat (SYNC + 4) tick();
  endtask

  // Master side: sends tx MSB first, returns what it sampled from miso.
  task automatic do_byte(input logic [1:0] m, input logic [7:0] tx, input int nbits,
                         output logic [7:0] rx);
    logic ms;
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!m[0]) begin
        mosi = tx[7-i];
        half();
        rx = {rx[6:0], miso};
        ms = miso;
        sclk = ~m[1];
        half();
        if (i != 7 && miso !== ms) glitches++;
        sclk = m[1];
      end else begin
        sclk = ~m[1];
        mosi = tx[7-i];
        half();
        rx = {rx[6:0], miso};
        ms = miso;
        sclk = m[1];
        half();
        if (miso !== ms) glitches++;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] r, r2;
    int a0;
    int waited;
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; mode = 2'd0; txdata = 8'h00;
    repeat (3) tick();
    chk("reset miso", miso, 1'b0);
    chk("reset miso_oe", miso_oe, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset tx_ack", tx_ack, 1'b0);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset rxdata", rxdata, 8'h00);
    rst = 1'b0;
    repeat (5) tick();

    rx_log.delete(); a0 = ack_cnt; glitches = 0; txdata = 8'hA5;
    frame_begin(2'd0);
    chk("m0 busy in frame", busy, 1'b1);
    chk("m0 miso_oe in frame", miso_oe, 1'b1);
    do_byte(2'd0, 8'h3C, 8, r);
    frame_end();
    chk("m0 rx count", rx_log.size(), 1);
    chk("m0 rxdata", rx_at(0), 8'h3C);
    chk("m0 master rx", r, 8'hA5);
    chk("m0 tx_ack count", ack_cnt - a0, 2);
    chk("m0 busy after", busy, 1'b0);
    chk("m0 miso glitches", glitches, 0);

    for (int m = 1; m < 4; m++) begin
      rx_log.delete(); glitches = 0; txdata = 8'h81;
      frame_begin(m[1:0]);
      do_byte(m[1:0], 8'h7E, 8, r);
      frame_end();
      chk($sformatf("mode%0d rx count", m), rx_log.size(), 1);
      chk($sformatf("mode%0d rxdata", m), rx_at(0), 8'h7E);
      chk($sformatf("mode%0d master rx", m), r, 8'h81);
      chk($sformatf("mode%0d miso glitches", m), glitches, 0);
    end

    rx_log.delete(); a0 = ack_cnt; txdata = 8'h12;
    fork
      begin
        frame_begin(2'd3);
        do_byte(2'd3, 8'hF0, 8, r);
      end
      begin
        waited = 0;
        while (ack_cnt == a0 && waited < 400) begin
          @(negedge clk);
          waited++;
        end
        @(posedge clk);
        #1 txdata = 8'h34;
      end
    join
    do_byte(2'd3, 8'h0F, 8, r2);
    frame_end();
    chk("two-byte rx count", rx_log.size(), 2);
    chk("two-byte rx 0", rx_at(0), 8'hF0);
    chk("two-byte rx 1", rx_at(1), 8'h0F);
    chk("two-byte master rx 0", r, 8'h12);
    chk("two-byte master rx 1", r2, 8'h34);

    rx_log.delete(); a0 = ack_cnt; txdata = 8'hE7;
    frame_begin(2'd0);
    do_byte(2'd0, 8'hFF, 5, r);
    half();
    ss_n = 1'b1;
    repeat (SYNC + 2) tick();
    chk("partial busy", busy, 1'b0);
    chk("partial miso_oe", miso_oe, 1'b0);
    repeat (10) tick();
    chk("partial rx count", rx_log.size(), 0);
    chk("partial rxdata kept", rxdata, 8'h0F);
    chk("partial tx_ack count", ack_cnt - a0, 1);
    txdata = 8'h3A;
    frame_begin(2'd0);
    do_byte(2'd0, 8'h55, 8, r);
    frame_end();
    chk("after partial rxdata", rx_at(0), 8'h55);
    chk("after partial master rx", r, 8'h3A);

    rx_log.delete(); txdata = 8'h66;
    frame_begin(2'd1);
    do_byte(2'd1, 8'hAA, 3, r);
    rst = 1'b1;
    ss_n = 1'b1;
    tick();
    chk("rst miso", miso, 1'b0);
    chk("rst miso_oe", miso_oe, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst tx_ack", tx_ack, 1'b0);
    chk("rst rx_valid", rx_valid, 1'b0);
    chk("rst rxdata", rxdata, 8'h00);
    rst = 1'b0;
    repeat (10) tick();
    txdata = 8'h99;
    frame_begin(2'd1);
    do_byte(2'd1, 8'hC3, 8, r);
    frame_end();
    chk("post-rst rx count", rx_log.size(), 1);
    chk("post-rst rxdata", rx_at(0), 8'hC3);
    chk("post-rst master rx", r, 8'h99);

    rx_log.delete(); txdata = 8'h5A;
    fork
      begin
        frame_begin(2'd0);
        do_byte(2'd0, 8'hB7, 8, r);
      end
      begin
        repeat (60) tick();
        mode = 2'd3;
      end
    join
    frame_end();
    chk("mode toggle rx count", rx_log.size(), 1);
    chk("mode toggle rxdata", rx_at(0), 8'hB7);
    chk("mode toggle master rx", r, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
